// File: rtl/sad_frame_engine.sv
// Purpose : sum of absolute differences over one block of packed 8-bit pixels, handed to writeback.
// Latency : frame_shift rises 3 cycles after the cycle carrying the last beat (2-stage datapath + present).
// Backpr. : pix_ready only while beats remain; result held in PRESENT until WB_stall=0 at a rising edge.
//
// Ports:
//   Clk, Reset_n           clock (rising edge) and asynchronous active-low reset
//   start, start_dest      begin a block / destination register, taken when start_ready=1
//   start_ready            high in IDLE, and in PRESENT during the consuming cycle
//   pix_valid, pix_ready   beat handshake; frame_pixel/window_pixel carry 4 bytes each, byte 0 lowest
//   WB_stall               writeback refuses the result this cycle
//   frame_shift            result valid; SAD_WB_value/SAD_dest_reg stable while high
//   busy                   state != IDLE
module sad_frame_engine #(
    parameter int PIXELS_PER_BLOCK = 16,
    parameter int ACC_W            = 32
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        start,
    input  logic [4:0]  start_dest,
    output logic        start_ready,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [31:0] frame_pixel,
    input  logic [31:0] window_pixel,
    input  logic        WB_stall,
    output logic        frame_shift,
    output logic [31:0] SAD_WB_value,
    output logic [4:0]  SAD_dest_reg,
    output logic        busy
);

    localparam int BEATS = PIXELS_PER_BLOCK / 4;
    localparam int CNT_W = $clog2(BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [33:0] ACC_MAX = (34'd1 << ACC_W) - 34'd1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        DRAIN   = 2'd2,
        PRESENT = 2'd3
    } state_t;

    state_t           state, stateNext;
    logic [CNT_W-1:0] beatCnt;
    logic             drainCnt;
    logic             startAccept;
    logic             beatXfer;
    logic [4:0]       destReg;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] accSat;
    logic [33:0]      accSum;

    // stage 1: per-byte absolute differences of the last transferred beat
    logic             s1Vld;
    logic [7:0]       s1Diff [4];
    logic [9:0]       s1Sum;

    function automatic logic [7:0] absDiff(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    assign pix_ready    = (state == ACCUM) && (beatCnt < CNT_W'(BEATS));
    assign beatXfer     = pix_valid && pix_ready;
    assign start_ready  = (state == IDLE) || ((state == PRESENT) && !WB_stall);
    assign frame_shift  = (state == PRESENT);
    assign busy         = (state != IDLE);
    assign SAD_WB_value = 32'(acc);
    assign SAD_dest_reg = destReg;

    // stage 2 adder: widen past ACC_W so overflow is visible, then clamp
    assign s1Sum  = {2'b00, s1Diff[0]} + {2'b00, s1Diff[1]} + {2'b00, s1Diff[2]} + {2'b00, s1Diff[3]};
    assign accSum = 34'(acc) + 34'(s1Sum);
    assign accSat = (accSum > ACC_MAX) ? ACC_MAX[ACC_W-1:0] : accSum[ACC_W-1:0];

    always_comb begin
        stateNext   = state;
        startAccept = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    stateNext   = ACCUM;
                    startAccept = 1'b1;
                end
            end
            ACCUM: begin
                if (beatXfer && (beatCnt == LAST_BEAT)) stateNext = DRAIN;
            end
            DRAIN: begin
                // second drain cycle: stage 2 has absorbed the final beat
                if (drainCnt) stateNext = PRESENT;
            end
            PRESENT: begin
                if (!WB_stall) begin
                    if (start) begin
                        stateNext   = ACCUM;
                        startAccept = 1'b1;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            beatCnt  <= '0;
            drainCnt <= 1'b0;
            destReg  <= '0;
            s1Vld    <= 1'b0;
            s1Diff   <= '{default: '0};
            acc      <= '0;
        end else begin
            state    <= stateNext;
            drainCnt <= (state == DRAIN) ? ~drainCnt : 1'b0;

            if (startAccept) begin
                beatCnt <= '0;
                destReg <= start_dest;
            end else if (beatXfer) begin
                beatCnt <= beatCnt + 1'b1;
            end

            s1Vld <= beatXfer;
            if (beatXfer) begin
                for (int i = 0; i < 4; i++) begin
                    s1Diff[i] <= absDiff(frame_pixel[8*i +: 8], window_pixel[8*i +: 8]);
                end
            end

            // s1Vld is never set in IDLE/PRESENT, so clear and add cannot collide
            if (startAccept) begin
                acc <= '0;
            end else if (s1Vld) begin
                acc <= accSat;
            end
        end
    end

endmodule

// File: tb/tb_sad_frame_engine.sv
// Purpose : directed self-checking bench for sad_frame_engine (32-bit and 8-bit accumulator instances).
// Latency : inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpr. : exercises WB_stall holding PRESENT and pix_valid bubbles.
module tb_sad_frame_engine;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        start;
    logic [4:0]  start_dest;
    logic        pix_valid;
    logic [31:0] frame_pixel;
    logic [31:0] window_pixel;
    logic        WB_stall;

    logic        start_ready, pix_ready, frame_shift, busy;
    logic [31:0] SAD_WB_value;
    logic [4:0]  SAD_dest_reg;

    logic        start_ready8, pix_ready8, frame_shift8, busy8;
    logic [31:0] SAD_WB_value8;
    logic [4:0]  SAD_dest_reg8;

    int checks = 0;
    int errors = 0;
    bit sawShift;

    always #5 Clk = ~Clk;

    sad_frame_engine #(.PIXELS_PER_BLOCK(16), .ACC_W(32)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .start(start), .start_dest(start_dest),
        .start_ready(start_ready), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .frame_pixel(frame_pixel), .window_pixel(window_pixel), .WB_stall(WB_stall),
        .frame_shift(frame_shift), .SAD_WB_value(SAD_WB_value),
        .SAD_dest_reg(SAD_dest_reg), .busy(busy)
    );

    // narrow accumulator shares all inputs; it shows saturation instead of wrap
    sad_frame_engine #(.PIXELS_PER_BLOCK(16), .ACC_W(8)) dut8 (
        .Clk(Clk), .Reset_n(Reset_n), .start(start), .start_dest(start_dest),
        .start_ready(start_ready8), .pix_valid(pix_valid), .pix_ready(pix_ready8),
        .frame_pixel(frame_pixel), .window_pixel(window_pixel), .WB_stall(WB_stall),
        .frame_shift(frame_shift8), .SAD_WB_value(SAD_WB_value8),
        .SAD_dest_reg(SAD_dest_reg8), .busy(busy8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] f, input logic [31:0] w);
        pix_valid    = 1'b1;
        frame_pixel  = f;
        window_pixel = w;
        step();
        pix_valid    = 1'b0;
    endtask

    // checks the presented result on both instances
    task automatic chkResult(input string tag, input logic [31:0] exp, input logic [4:0] dest);
        chk({tag, "_shift"}, {31'd0, frame_shift}, 32'd1);
        chk({tag, "_value"}, SAD_WB_value, exp);
        chk({tag, "_dest"}, {27'd0, SAD_dest_reg}, {27'd0, dest});
        chk({tag, "_value8"}, SAD_WB_value8, (exp > 32'd255) ? 32'd255 : exp);
    endtask

    task automatic startBlock(input logic [4:0] dest);
        start      = 1'b1;
        start_dest = dest;
        step();
        start      = 1'b0;
    endtask

    initial begin
        Reset_n      = 1'b0;
        start        = 1'b0;
        start_dest   = '0;
        pix_valid    = 1'b0;
        frame_pixel  = '0;
        window_pixel = '0;
        WB_stall     = 1'b0;

        // reset state
        step(); step();
        chk("rst_shift", {31'd0, frame_shift}, 32'd0);
        chk("rst_value", SAD_WB_value, 32'd0);
        chk("rst_dest", {27'd0, SAD_dest_reg}, 32'd0);
        chk("rst_pixrdy", {31'd0, pix_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_strdy", {31'd0, start_ready}, 32'd1);
        Reset_n = 1'b1;
        step();

        // basic: 4 beats of 8 per byte -> 4*4*8 = 0x80, dest 5
        startBlock(5'd5);
        chk("basic_accum_busy", {31'd0, busy}, 32'd1);
        chk("basic_accum_pixrdy", {31'd0, pix_ready}, 32'd1);
        chk("basic_accum_strdy", {31'd0, start_ready}, 32'd0);
        for (int i = 0; i < 4; i++) beat(32'h10101010, 32'h08080808);
        chk("basic_d1_shift", {31'd0, frame_shift}, 32'd0);
        chk("basic_d1_pixrdy", {31'd0, pix_ready}, 32'd0);
        step();
        chk("basic_d2_shift", {31'd0, frame_shift}, 32'd0);
        step();
        chkResult("basic", 32'h80, 5'd5);
        chk("basic_present_strdy", {31'd0, start_ready}, 32'd1);
        step();
        chk("basic_after_shift", {31'd0, frame_shift}, 32'd0);
        chk("basic_after_busy", {31'd0, busy}, 32'd0);

        // abs/max: 255 per byte -> 16*255 = 0xFF0, then back-to-back with swapped operands
        startBlock(5'd2);
        for (int i = 0; i < 4; i++) beat(32'h00FF00FF, 32'hFF00FF00);
        step(); step();
        chkResult("abs", 32'hFF0, 5'd2);
        start      = 1'b1;
        start_dest = 5'd7;
        step();
        start      = 1'b0;
        chk("b2b_shift", {31'd0, frame_shift}, 32'd0);
        chk("b2b_pixrdy", {31'd0, pix_ready}, 32'd1);
        chk("b2b_dest", {27'd0, SAD_dest_reg}, 32'd7);
        chk("b2b_acc_clear", SAD_WB_value, 32'd0);
        for (int i = 0; i < 4; i++) beat(32'hFF00FF00, 32'h00FF00FF);
        step(); step();
        chkResult("swap", 32'hFF0, 5'd7);
        step();
        chk("swap_after_busy", {31'd0, busy}, 32'd0);

        // bubbles carry garbage data that must not accumulate; diffs 3,1,1,3 -> 8/beat -> 0x20
        startBlock(5'd11);
        for (int i = 0; i < 4; i++) begin
            beat(32'h01020304, 32'h04030201);
            frame_pixel  = 32'hFFFFFFFF;
            window_pixel = 32'h00000000;
            if (i < 3) begin
                chk("bubble_pixrdy", {31'd0, pix_ready}, 32'd1);
                step();
            end
        end
        WB_stall = 1'b1;
        step(); step();
        for (int i = 0; i < 5; i++) begin
            chkResult("stall", 32'h20, 5'd11);
            chk("stall_strdy", {31'd0, start_ready}, 32'd0);
            step();
        end
        chk("stall_still_present", {31'd0, frame_shift}, 32'd1);
        WB_stall = 1'b0;
        #1;
        chk("stall_release_strdy", {31'd0, start_ready}, 32'd1);
        step();
        chk("stall_consumed_shift", {31'd0, frame_shift}, 32'd0);
        chk("stall_consumed_busy", {31'd0, busy}, 32'd0);

        // ignored inputs: pix_valid in IDLE, start during ACCUM
        pix_valid    = 1'b1;
        frame_pixel  = 32'hFFFFFFFF;
        window_pixel = 32'h00000000;
        step();
        chk("idle_pixrdy", {31'd0, pix_ready}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        step();
        pix_valid = 1'b0;
        startBlock(5'd3);
        beat(32'h10101010, 32'h08080808);
        beat(32'h10101010, 32'h08080808);
        start      = 1'b1;
        start_dest = 5'd9;
        beat(32'h10101010, 32'h08080808);
        start      = 1'b0;
        chk("ign_dest", {27'd0, SAD_dest_reg}, 32'd3);
        chk("ign_pixrdy", {31'd0, pix_ready}, 32'd1);
        beat(32'h10101010, 32'h08080808);
        step(); step();
        chkResult("ign", 32'h80, 5'd3);
        step();

        // asynchronous reset mid-block
        startBlock(5'd13);
        beat(32'h10101010, 32'h08080808);
        beat(32'h10101010, 32'h08080808);
        chk("pre_abort_value", SAD_WB_value, 32'h20);
        #3;
        Reset_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_value", SAD_WB_value, 32'd0);
        chk("arst_dest", {27'd0, SAD_dest_reg}, 32'd0);
        chk("arst_pixrdy", {31'd0, pix_ready}, 32'd0);
        chk("arst_strdy", {31'd0, start_ready}, 32'd1);
        pix_valid = 1'b1;
        step(); step();
        Reset_n = 1'b1;
        sawShift = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (frame_shift || frame_shift8) sawShift = 1'b1;
        end
        pix_valid = 1'b0;
        chk("abort_no_shift", {31'd0, sawShift}, 32'd0);
        chk("abort_idle", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
